// File: rtl/noc_output_port_arbiter_if.sv
// Handshake bundle between the input buffers of one output port and its
// round-robin arbiter. The master side (input buffers / link) drives the
// requests, flit qualifiers and downstream readiness; the slave side
// (the arbiter) returns the registered grant and status.
interface noc_output_port_arbiter_if #(
  parameter int NUM_PORTS = 5
);
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] flit_valid;
  logic [NUM_PORTS-1:0] flit_tail;
  logic                 out_ready;
  logic [NUM_PORTS-1:0] grant;
  logic                 fwd_fire;
  logic                 busy;
  logic                 wdog_trip;

  modport master (
    output req, flit_valid, flit_tail, out_ready,
    input  grant, fwd_fire, busy, wdog_trip
  );

  modport slave (
    input  req, flit_valid, flit_tail, out_ready,
    output grant, fwd_fire, busy, wdog_trip
  );
endinterface

// File: rtl/noc_output_port_arbiter.sv
// Per-output-port round-robin wormhole arbiter of the 5-port mesh router.
// A head-flit request wins a one-hot registered grant that is held until
// the packet's tail flit is forwarded; the next search then starts at the
// port after the previous owner, so continuous requesters are served in
// strict rotation with a one-cycle bubble between packets.
//
// Optional feature macro: ARB_WATCHDOG_EN
//   defined   : a stall counter forces release of a lock that has not
//               forwarded a flit for WDOG_CYCLES cycles, pulsing wdog_trip.
//   undefined : no counter; wdog_trip is tied low and only a tail releases.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no owner; grant=0; searching req from rr_ptr each cycle
// LOCKED | grant[gnt_idx]=1; forwarding that port's packet until its tail
module noc_output_port_arbiter #(
  parameter int NUM_PORTS   = 5,
  parameter int WDOG_CYCLES = 64,
  parameter int WDOG_W      = 7
) (
  input logic                    clk,
  input logic                    rst_n,
  noc_output_port_arbiter_if.slave port_if
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // The stall counter must be able to hold WDOG_CYCLES without wrapping.
  localparam bit WDOG_CFG_OK = ((1 << WDOG_W) > WDOG_CYCLES);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state;
  logic [NUM_PORTS-1:0] grant_q;
  logic                 busy_q;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     gnt_idx;

  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_found;
  logic [PTR_W-1:0]     next_ptr;
  logic                 fire;
  logic                 tail_fire;

`ifdef ARB_WATCHDOG_EN
  logic [WDOG_W-1:0]    wdog_cnt;
  logic                 wdog_trip_q;
  logic                 wdog_expire;
`endif

  // Port index base+offset, wrapped into 0..NUM_PORTS-1 (offset < NUM_PORTS).
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int              offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_PORTS) begin
      sum = sum - NUM_PORTS;
    end
    return PTR_W'(sum);
  endfunction

  // Round-robin search: first requester at or after rr_ptr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!pick_found && port_if.req[wrap_idx(rr_ptr, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_idx(rr_ptr, k);
      end
    end
  end

  // Pointer value to resume searching from after the current owner releases.
  assign next_ptr = wrap_idx(gnt_idx, 1);

  // A flit moves only from the granted port, and only when downstream accepts.
  // grant_q is zero in IDLE, so this cannot fire outside LOCKED.
  assign fire      = (|(grant_q & port_if.flit_valid)) & port_if.out_ready;
  assign tail_fire = (|(grant_q & port_if.flit_valid & port_if.flit_tail))
                     & port_if.out_ready;

`ifdef ARB_WATCHDOG_EN
  // wdog_cnt holds the stall cycles already elapsed in this lock; a stall in
  // the current cycle brings it to WDOG_CYCLES, which releases on this edge.
  assign wdog_expire = !fire && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`endif

  // Arbitration FSM: grant/busy/pointer (and watchdog) all registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      rr_ptr      <= '0;
      gnt_idx     <= '0;
`ifdef ARB_WATCHDOG_EN
      wdog_cnt    <= '0;
      wdog_trip_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_WATCHDOG_EN
      wdog_trip_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_found) begin
            state   <= LOCKED;
            grant_q <= NUM_PORTS'(1) << pick_idx;
            busy_q  <= 1'b1;
            gnt_idx <= pick_idx;
`ifdef ARB_WATCHDOG_EN
            wdog_cnt <= '0;
`endif
          end
        end

        LOCKED: begin
          if (tail_fire) begin
            state   <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            rr_ptr  <= next_ptr;
`ifdef ARB_WATCHDOG_EN
            wdog_cnt <= '0;
`endif
          end
`ifdef ARB_WATCHDOG_EN
          else if (wdog_expire) begin
            // Stuck owner: drop it and move on as if its tail had gone.
            state       <= IDLE;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            rr_ptr      <= next_ptr;
            wdog_cnt    <= '0;
            wdog_trip_q <= 1'b1;
          end else if (fire) begin
            wdog_cnt <= '0;
          end else begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
          end
`endif
        end

        default: begin
          state   <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign port_if.grant    = grant_q;
  assign port_if.busy     = busy_q;
  assign port_if.fwd_fire = fire;
`ifdef ARB_WATCHDOG_EN
  assign port_if.wdog_trip = wdog_trip_q;
`else
  assign port_if.wdog_trip = 1'b0;
`endif

  // Structural invariants of the grant path.
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
                                     $onehot0(grant_q));
  a_fire_busy     : assert property (@(posedge clk) disable iff (!rst_n)
                                     fire |-> busy_q);
  a_busy_grant    : assert property (@(posedge clk) disable iff (!rst_n)
                                     busy_q == (grant_q != '0));
  a_wdog_cfg      : assert property (@(posedge clk) WDOG_CFG_OK);

endmodule

// File: tb/tb_noc_output_port_arbiter.sv
// Self-checking bench for noc_output_port_arbiter: a packet-level ownership
// model is compared against the DUT on every falling edge, and directed
// scenarios pin grant sequencing, stalls, async reset and (when built with
// ARB_WATCHDOG_EN) the forced release.
module tb_noc_output_port_arbiter;

  localparam int N           = 5;
  localparam int WDOG_CYCLES = 64;
`ifdef ARB_WATCHDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;

  noc_output_port_arbiter_if #(.NUM_PORTS(N)) bus ();

  noc_output_port_arbiter #(
    .NUM_PORTS  (N),
    .WDOG_CYCLES(WDOG_CYCLES),
    .WDOG_W     (7)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .port_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Ownership model: who owns the output, where the next search starts,
  // how long the owner has gone without moving a flit.
  int m_owner;
  int m_ptr;
  int m_stall;
  bit m_trip;

  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_stall <= 0;
      m_trip  <= 1'b0;
    end else begin
      m_trip <= 1'b0;
      if (m_owner < 0) begin
        m_owner <= rr_pick(bus.req, m_ptr);
        m_stall <= 0;
      end else if (bus.flit_valid[m_owner] && bus.out_ready) begin
        m_stall <= 0;
        if (bus.flit_tail[m_owner]) begin
          m_owner <= -1;
          m_ptr   <= (m_owner + 1) % N;
        end
      end else if (WDOG_ON && (m_stall + 1 >= WDOG_CYCLES)) begin
        m_owner <= -1;
        m_ptr   <= (m_owner + 1) % N;
        m_stall <= 0;
        m_trip  <= 1'b1;
      end else begin
        m_stall <= m_stall + 1;
      end
    end
  end

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] one;
    one = 1;
    return (m_owner < 0) ? '0 : (one << m_owner);
  endfunction

  function automatic logic exp_fire();
    return (m_owner >= 0) && bus.flit_valid[m_owner] && bus.out_ready;
  endfunction

  int fire_count = 0;
  always @(negedge clk) if (bus.fwd_fire === 1'b1) fire_count <= fire_count + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] v,
                       input logic [N-1:0] t, input logic rdy);
    bus.req        = r;
    bus.flit_valid = v;
    bus.flit_tail  = t;
    bus.out_ready  = rdy;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drive('0, '0, '0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [N-1:0] seq_exp [12];
  int base;
  int held;
  bit tripped;

  initial begin
    rst_n = 1'b0;
    drive('0, '0, '0, 1'b0);

    fork
      forever begin
        @(negedge clk);
        check("cyc_grant", 32'(bus.grant), 32'(exp_grant()));
        check("cyc_busy", 32'(bus.busy), 32'(m_owner >= 0));
        check("cyc_fire", 32'(bus.fwd_fire), 32'(exp_fire()));
        check("cyc_wdog", 32'(bus.wdog_trip), 32'(m_trip));
      end
    join_none

    // Reset state
    tick();
    tick();
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_wdog", 32'(bus.wdog_trip), 32'h0);
    rst_n = 1'b1;

    // 1: single requester, 3-flit packet
    drive(5'b00100, '0, '0, 1'b1);
    tick();
    check("t1_grant", 32'(bus.grant), 32'h04);
    base = fire_count;
    drive('0, 5'b00100, '0, 1'b1);
    tick();
    tick();
    drive('0, 5'b00100, 5'b00100, 1'b1);
    tick();
    check("t1_release", 32'(bus.grant), 32'h0);
    check("t1_busy", 32'(bus.busy), 32'h0);
    check("t1_fires", 32'(fire_count - base), 32'd3);
    drive('0, '0, '0, 1'b1);

    // 2: all requesting, single-flit packets -> strict rotation with bubbles
    reset_dut();
    seq_exp = '{5'h01, 5'h00, 5'h02, 5'h00, 5'h04, 5'h00,
                5'h08, 5'h00, 5'h10, 5'h00, 5'h01, 5'h00};
    drive(5'b11111, 5'b11111, 5'b11111, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("t2_seq%0d", i), 32'(bus.grant), 32'(seq_exp[i]));
    end
    drive('0, '0, '0, 1'b1);

    // 3: lock on port 1, downstream back-pressure for 10 cycles
    drive(5'b00010, '0, '0, 1'b1);
    tick();
    check("t3_grant", 32'(bus.grant), 32'h02);
    base = fire_count;
    drive('0, 5'b00010, '0, 1'b1);
    tick();
    drive('0, 5'b00010, '0, 1'b0);
    repeat (10) tick();
    check("t3_hold", 32'(bus.grant), 32'h02);
    check("t3_nofire", 32'(fire_count - base), 32'd1);
    drive('0, 5'b00010, 5'b00010, 1'b1);
    tick();
    check("t3_release", 32'(bus.grant), 32'h0);
    check("t3_fires", 32'(fire_count - base), 32'd2);
    drive('0, '0, '0, 1'b1);

    // 4: lock on port 3, competing request, owner starves for 5 cycles
    drive(5'b01000, '0, '0, 1'b1);
    tick();
    check("t4_grant", 32'(bus.grant), 32'h08);
    base = fire_count;
    drive(5'b01001, 5'b00001, '0, 1'b1);
    repeat (5) tick();
    check("t4_hold", 32'(bus.grant), 32'h08);
    check("t4_nofire", 32'(fire_count - base), 32'd0);
    drive(5'b00001, 5'b01000, 5'b01000, 1'b1);
    tick();
    check("t4_release", 32'(bus.grant), 32'h0);
    check("t4_fires", 32'(fire_count - base), 32'd1);
    drive(5'b00001, '0, '0, 1'b1);
    tick();
    check("t4_next", 32'(bus.grant), 32'h01);
    drive('0, 5'b00001, 5'b00001, 1'b1);
    tick();
    check("t4_done", 32'(bus.grant), 32'h0);
    drive('0, '0, '0, 1'b1);

    // 5: async reset in the middle of port 2's packet
    drive(5'b00100, '0, '0, 1'b1);
    tick();
    check("t5_grant", 32'(bus.grant), 32'h04);
    drive('0, 5'b00100, '0, 1'b1);
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_grant", 32'(bus.grant), 32'h0);
    check("t5_async_busy", 32'(bus.busy), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(5'b11111, '0, '0, 1'b1);
    tick();
    check("t5_first", 32'(bus.grant), 32'h01);
    drive('0, 5'b00001, 5'b00001, 1'b1);
    tick();
    check("t5_done", 32'(bus.grant), 32'h0);
    drive('0, '0, '0, 1'b1);

`ifdef ARB_WATCHDOG_EN
    // 6: port 4 stalls until the watchdog forces it off
    drive(5'b10000, '0, '0, 1'b1);
    tick();
    check("t6_grant", 32'(bus.grant), 32'h10);
    drive('0, '0, '0, 1'b1);
    held    = 0;
    tripped = 1'b0;
    for (int i = 0; i < 200 && !tripped; i++) begin
      if (bus.grant == 5'b10000) held++;
      tick();
      if (bus.wdog_trip) tripped = 1'b1;
    end
    check("t6_tripped", 32'(tripped), 32'h1);
    check("t6_held", 32'(held), 32'(WDOG_CYCLES));
    check("t6_grant0", 32'(bus.grant), 32'h0);
    drive(5'b11111, '0, '0, 1'b1);
    tick();
    check("t6_pulse", 32'(bus.wdog_trip), 32'h0);
    check("t6_next", 32'(bus.grant), 32'h01);
    drive('0, 5'b00001, 5'b00001, 1'b1);
    tick();
    drive('0, '0, '0, 1'b1);
`endif

    tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
